// File: rtl/instruction_fetch.sv
// Fetch stage in front of the 8x16 register file: reads r7, issues a memory read and hands the word to decode.
// Optional perf counters (fetch/stall) are built when INSTRUCTION_FETCH_PERF_EN is defined.
module instruction_fetch #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_count_enable,
  input  logic             i_flush,
  output logic             o_mem_req,
  output logic [WIDTH-1:0] o_mem_addr,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_instr_valid,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_instr_pc,
`ifdef INSTRUCTION_FETCH_PERF_EN
  output logic [WIDTH-1:0] o_fetch_count,
  output logic [WIDTH-1:0] o_stall_count,
`endif
  input  logic             i_instr_ready
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t state, state_next;
  logic   discard;
  logic   handshake;
  logic   capture;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // A flush in IDLE holds off the fetch one cycle so the redirected r7 is what gets sampled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!i_flush) state_next = REQ;
      REQ:     if (i_mem_ack) state_next = capture ? HOLD : IDLE;
      HOLD:    if (handshake || i_flush) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    handshake      = (state == HOLD) && o_instr_valid && i_instr_ready && !i_flush;
    capture        = !discard && !i_flush;
    o_count_enable = handshake;
  end

  // The request is never withdrawn once issued; a flush only marks the pending word for discard.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req     <= 1'b0;
      o_mem_addr    <= '0;
      o_instr_valid <= 1'b0;
      o_instr       <= '0;
      o_instr_pc    <= '0;
      discard       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_flush) begin
            o_mem_req  <= 1'b1;
            o_mem_addr <= i_pc;
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            discard   <= 1'b0;
            if (capture) begin
              o_instr       <= i_mem_rdata;
              o_instr_pc    <= o_mem_addr;
              o_instr_valid <= 1'b1;
            end
          end else if (i_flush) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake || i_flush) o_instr_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef INSTRUCTION_FETCH_PERF_EN
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic stall;
  assign stall = (o_mem_req && !i_mem_ack) || (o_instr_valid && !i_instr_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fetch_count <= '0;
      o_stall_count <= '0;
    end else begin
      if (handshake) o_fetch_count <= sat_inc(o_fetch_count);
      if (stall)     o_stall_count <= sat_inc(o_stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed-vector bench for instruction_fetch; r7 behaviour is modelled by driving i_pc after each accepted edge.
// Build with INSTRUCTION_FETCH_PERF_EN defined to also check the perf counters.
module tb_instruction_fetch;
  localparam int WIDTH = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic [WIDTH-1:0] i_pc;
  logic             o_count_enable;
  logic             i_flush;
  logic             o_mem_req;
  logic [WIDTH-1:0] o_mem_addr;
  logic             i_mem_ack;
  logic [WIDTH-1:0] i_mem_rdata;
  logic             o_instr_valid;
  logic [WIDTH-1:0] o_instr;
  logic [WIDTH-1:0] o_instr_pc;
  logic             i_instr_ready;
`ifdef INSTRUCTION_FETCH_PERF_EN
  logic [WIDTH-1:0] o_fetch_count;
  logic [WIDTH-1:0] o_stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  instruction_fetch #(.WIDTH(WIDTH)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pc           (i_pc),
    .o_count_enable (o_count_enable),
    .i_flush        (i_flush),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_ack      (i_mem_ack),
    .i_mem_rdata    (i_mem_rdata),
    .o_instr_valid  (o_instr_valid),
    .o_instr        (o_instr),
    .o_instr_pc     (o_instr_pc),
`ifdef INSTRUCTION_FETCH_PERF_EN
    .o_fetch_count  (o_fetch_count),
    .o_stall_count  (o_stall_count),
`endif
    .i_instr_ready  (i_instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_pc = 16'h0010; i_flush = 1'b0;
    i_mem_ack = 1'b0; i_mem_rdata = '0; i_instr_ready = 1'b1;
    #2;
    chk("rst_req",   32'(o_mem_req), 32'h0);
    chk("rst_valid", 32'(o_instr_valid), 32'h0);
    chk("rst_addr",  32'(o_mem_addr), 32'h0);
    chk("rst_instr", 32'(o_instr), 32'h0);
    chk("rst_ce",    32'(o_count_enable), 32'h0);
    step(); step();
    i_rst_n = 1'b1;

    // zero-wait fetch from 0x0010
    step();
    chk("t1_req",  32'(o_mem_req), 32'h1);
    chk("t1_addr", 32'(o_mem_addr), 32'h0010);
    chk("t1_ce_req", 32'(o_count_enable), 32'h0);
    i_mem_ack = 1'b1; i_mem_rdata = 16'hA5A5;
    step();
    i_mem_ack = 1'b0;
    chk("t1_valid", 32'(o_instr_valid), 32'h1);
    chk("t1_instr", 32'(o_instr), 32'hA5A5);
    chk("t1_ipc",   32'(o_instr_pc), 32'h0010);
    chk("t1_req_off", 32'(o_mem_req), 32'h0);
    chk("t1_ce",    32'(o_count_enable), 32'h1);
    step();
    i_pc = 16'h0011;
    chk("t1_valid_off", 32'(o_instr_valid), 32'h0);
    chk("t1_ce_off",    32'(o_count_enable), 32'h0);
`ifdef INSTRUCTION_FETCH_PERF_EN
    chk("t1_fetch_cnt", 32'(o_fetch_count), 32'h1);
    chk("t1_stall_cnt", 32'(o_stall_count), 32'h0);
`endif
    step();
    chk("t1_next_addr", 32'(o_mem_addr), 32'h0011);

    // ack delayed three cycles, then decoder stalls five cycles
    for (int i = 0; i < 3; i++) begin
      chk("t2_req",  32'(o_mem_req), 32'h1);
      chk("t2_addr", 32'(o_mem_addr), 32'h0011);
      chk("t2_ce",   32'(o_count_enable), 32'h0);
      step();
    end
    chk("t2_req4",  32'(o_mem_req), 32'h1);
    chk("t2_addr4", 32'(o_mem_addr), 32'h0011);
    i_mem_ack = 1'b1; i_mem_rdata = 16'h1234; i_instr_ready = 1'b0;
    step();
    i_mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", 32'(o_instr_valid), 32'h1);
      chk("t3_instr", 32'(o_instr), 32'h1234);
      chk("t3_ce",    32'(o_count_enable), 32'h0);
      step();
    end
    i_instr_ready = 1'b1;
    #1;
    chk("t3_ce_pulse", 32'(o_count_enable), 32'h1);
    chk("t3_ipc",      32'(o_instr_pc), 32'h0011);
    step();
    i_pc = 16'h0012;
    chk("t3_ce_once", 32'(o_count_enable), 32'h0);

    // flush while waiting for memory: word must be dropped
    step();
    chk("t4_addr", 32'(o_mem_addr), 32'h0012);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_pc = 16'h0200;
    chk("t4_req_kept",  32'(o_mem_req), 32'h1);
    chk("t4_addr_kept", 32'(o_mem_addr), 32'h0012);
    i_mem_ack = 1'b1; i_mem_rdata = 16'hDEAD;
    step();
    i_mem_ack = 1'b0;
    chk("t4_no_valid", 32'(o_instr_valid), 32'h0);
    chk("t4_req_off",  32'(o_mem_req), 32'h0);
    step();
    chk("t4_no_valid2", 32'(o_instr_valid), 32'h0);
    chk("t4_new_addr",  32'(o_mem_addr), 32'h0200);

    // flush and ready together in HOLD
    i_mem_ack = 1'b1; i_mem_rdata = 16'hBEEF;
    step();
    i_mem_ack = 1'b0;
    chk("t5_instr", 32'(o_instr), 32'hBEEF);
    i_flush = 1'b1; i_instr_ready = 1'b1;
    #1;
    chk("t5_ce", 32'(o_count_enable), 32'h0);
    step();
    i_flush = 1'b0; i_pc = 16'h0300;
    chk("t5_valid_off", 32'(o_instr_valid), 32'h0);
    step();
    chk("t5_new_addr", 32'(o_mem_addr), 32'h0300);

    // asynchronous reset between edges in REQ
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("t6_req",   32'(o_mem_req), 32'h0);
    chk("t6_valid", 32'(o_instr_valid), 32'h0);
    chk("t6_addr",  32'(o_mem_addr), 32'h0);
`ifdef INSTRUCTION_FETCH_PERF_EN
    chk("t6_fetch_cnt", 32'(o_fetch_count), 32'h0);
    chk("t6_stall_cnt", 32'(o_stall_count), 32'h0);
`endif

    // wrap address 0xFFFF
    step();
    i_rst_n = 1'b1; i_pc = 16'hFFFF;
    step();
    chk("t7_addr", 32'(o_mem_addr), 32'hFFFF);
    i_mem_ack = 1'b1; i_mem_rdata = 16'h0F0F;
    step();
    i_mem_ack = 1'b0;
    chk("t7_ipc",   32'(o_instr_pc), 32'hFFFF);
    chk("t7_instr", 32'(o_instr), 32'h0F0F);
    step();
    i_pc = 16'h0000;
    step();
    chk("t7_wrap_addr", 32'(o_mem_addr), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage sitting directly upstream of the 8×16 register file.
- Reads the program counter (r7) from the register file and issues a 16-bit instruction-memory read at that address.
- Presents the returned word to the decoder through a valid/ready handshake.
- Pulses the register file's count-enable input on each accepted instruction so r7 post-increments.
- Discards in-flight or held instructions when execute redirects the PC via a flush.

Parameters:
- WIDTH, 16, instruction/address width; must match the register file data width.

Ports:
- i_clk  input  1  single clock; all state updates on its rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_pc  input  WIDTH  current program counter (register file r7).
- o_count_enable  output  1  to register file count enable; PC increment request.
- i_flush  input  1  asserted in the same cycle execute writes r7 (taken branch/jump).
- o_mem_req  output  1  instruction memory read request.
- o_mem_addr  output  WIDTH  registered read address.
- i_mem_ack  input  1  memory completes the read this cycle.
- i_mem_rdata  input  WIDTH  read data, valid when i_mem_ack=1.
- o_instr_valid  output  1  o_instr/o_instr_pc are valid.
- o_instr  output  WIDTH  fetched instruction.
- o_instr_pc  output  WIDTH  address the instruction was fetched from.
- i_instr_ready  input  1  decoder accepts this cycle.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; o_mem_req, o_mem_addr, o_instr_valid, o_instr, o_instr_pc, the discard flag = 0; o_count_enable=0.
- States:
  - IDLE: next cycle → REQ, registering o_mem_addr<=i_pc and o_mem_req<=1.
  - REQ: o_mem_req held 1, o_mem_addr stable until i_mem_ack.
  - HOLD: o_instr_valid=1, waiting for the decoder.
- REQ on i_mem_ack=1:
  - Discard flag=0 and i_flush=0: o_instr<=i_mem_rdata, o_instr_pc<=o_mem_addr, o_instr_valid<=1, o_mem_req<=0 → HOLD.
  - Discard flag=1 or i_flush=1: drop data, clear the discard flag, o_mem_req<=0 → IDLE. The new PC is visible to IDLE on the following cycle.
- REQ, i_flush=1 without ack: set the discard flag; the request must stay asserted with the same address until ack (no request withdrawal).
- HOLD:
  - Handshake = o_instr_valid & i_instr_ready & ~i_flush.
  - On handshake: o_instr_valid<=0 → IDLE.
  - i_flush=1: o_instr_valid<=0 → IDLE; the instruction is killed even if i_instr_ready=1.
- o_count_enable is combinational and equals the handshake term. r7 increments on the same edge, so i_pc is already updated when IDLE samples it. With a flush, the register file write to r7 has priority, and count_enable is 0 anyway.
- Throughput: a zero-wait memory (ack in the first REQ cycle) yields one instruction per 3 cycles (IDLE, REQ, HOLD-accept).
- o_instr/o_instr_pc hold their value while o_instr_valid=1 and do not change until the next capture.
- Addresses wrap naturally: PC 0xFFFF increments to 0x0000 in the register file; no special handling here.
- Reset mid-request: all outputs drop immediately. The memory must tolerate request abandonment only on reset.

Optional Feature:
- Macro: INSTRUCTION_FETCH_PERF_EN.
- Defined: adds outputs o_fetch_count[WIDTH] and o_stall_count[WIDTH], both reset to 0, saturating at 0xFFFF.
  - o_fetch_count increments per handshake.
  - o_stall_count increments per cycle with o_mem_req=1 & i_mem_ack=0, or o_instr_valid=1 & i_instr_ready=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then i_pc=0x0010, mem acks in 1st REQ cycle with 0xA5A5, ready=1 → o_mem_addr=0x0010, o_instr=0xA5A5, o_instr_pc=0x0010, one-cycle o_count_enable pulse; next fetch addr 0x0011.
- Mem ack delayed 3 cycles → o_mem_req and o_mem_addr stable all 4 REQ cycles; o_count_enable=0 until the decoder handshake.
- Decoder ready low 5 cycles in HOLD → o_instr_valid held, o_instr unchanged, no count pulse; pulse on the first ready cycle only.
- i_flush in REQ 1 cycle before ack, i_pc then becomes 0x0200 → returned word dropped, o_instr_valid never rises, next o_mem_addr=0x0200.
- i_flush and i_instr_ready in the same HOLD cycle → o_count_enable=0, o_instr_valid drops; next request uses the flushed PC.
- Assert i_rst_n=0 mid-REQ (async, between edges) → o_mem_req and o_instr_valid go 0 immediately. With PERF_EN, both counters read 0.
